// File: rtl/nn_requant_argmax.sv
// Requantizes the final-layer accumulator stream to DATA_W with round-half-up and
// saturation, forwards it through a 2-entry skid pipeline, and reports a per-vector argmax.
module nn_requant_argmax #(
  parameter int DATA_W  = 16,
  parameter int N_OUT   = 64,
  parameter int ACC_W   = 2*DATA_W + $clog2(N_OUT*2),
  parameter int SHIFT_W = 6,
  localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ACC_W-1:0]   s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic [DATA_W-1:0]  m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               argmax_valid,
  output logic [IDX_W-1:0]   argmax_idx,
  output logic [ACC_W-1:0]   argmax_val,
  output logic               err_len,
  output logic [15:0]        sat_count
);

  localparam int CNT_W = $clog2(N_OUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_OUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_OUT - 1);
  localparam logic signed [ACC_W:0] Y_MAX = (ACC_W+1)'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W:0] Y_MIN = (ACC_W+1)'(-(2**(DATA_W-1)));
  localparam logic [DATA_W-1:0] Y_MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] Y_MIN_D = {1'b1, {(DATA_W-1){1'b0}}};

  logic                     r_s_ready;
  logic [CNT_W-1:0]         r_cnt;
  logic [SHIFT_W-1:0]       r_shift;
  logic signed [ACC_W-1:0]  r_max_val;
  logic [IDX_W-1:0]         r_max_idx;
  logic                     r_out_valid, r_out_last, r_sk_valid, r_sk_last;
  logic [DATA_W-1:0]        r_out_data, r_sk_data;
  logic                     r_am_valid;
  logic [IDX_W-1:0]         r_am_idx;
  logic [ACC_W-1:0]         r_am_val;
  logic                     r_err;
  logic [15:0]              r_sat;

  logic                     w_s_ready, w_acc, w_drain, w_first, w_in_range, w_take;
  logic [SHIFT_W-1:0]       w_shift;
  logic signed [ACC_W-1:0]  w_x, w_best_val;
  logic [IDX_W-1:0]         w_best_idx;
  logic signed [ACC_W:0]    w_rnd, w_sum, w_t;
  logic                     w_hi, w_lo, w_sat;
  logic [DATA_W-1:0]        w_y;
  logic                     w_out_valid_n, w_out_last_n, w_sk_valid_n, w_sk_last_n;
  logic [DATA_W-1:0]        w_out_data_n, w_sk_data_n;

  // Readiness is forced low combinationally while rst is held so it reads 1 on the first free cycle.
  assign w_s_ready = r_s_ready & ~rst;
  assign w_acc     = s_axis_tvalid & w_s_ready;
  assign w_drain   = r_out_valid & m_axis_tready;
  assign w_first   = (r_cnt == '0);
  assign w_shift   = w_first ? cfg_shift : r_shift;
  assign w_x       = s_axis_tdata;

  assign w_rnd = (w_shift == '0) ? '0 : ((ACC_W+1)'(1) << (w_shift - SHIFT_W'(1)));
  assign w_sum = $signed({w_x[ACC_W-1], w_x}) + w_rnd;
  assign w_t   = w_sum >>> w_shift;
  assign w_hi  = (w_t > Y_MAX);
  assign w_lo  = (w_t < Y_MIN);
  assign w_sat = w_hi | w_lo;
  assign w_y   = w_hi ? Y_MAX_D : (w_lo ? Y_MIN_D : w_t[DATA_W-1:0]);

  // Running max including the current beat, so a tlast beat can report without an extra cycle.
  assign w_in_range = (r_cnt < CNT_MAX);
  assign w_take     = w_in_range & (w_first | (w_x > r_max_val));
  assign w_best_val = w_take ? w_x : r_max_val;
  assign w_best_idx = w_take ? r_cnt[IDX_W-1:0] : r_max_idx;

  always_comb begin
    w_out_valid_n = r_out_valid;
    w_out_data_n  = r_out_data;
    w_out_last_n  = r_out_last;
    w_sk_valid_n  = r_sk_valid;
    w_sk_data_n   = r_sk_data;
    w_sk_last_n   = r_sk_last;
    if (!r_out_valid || w_drain) begin
      if (r_sk_valid) begin
        w_out_valid_n = 1'b1;
        w_out_data_n  = r_sk_data;
        w_out_last_n  = r_sk_last;
        if (w_acc) begin
          w_sk_data_n = w_y;
          w_sk_last_n = s_axis_tlast;
        end else begin
          w_sk_valid_n = 1'b0;
        end
      end else if (w_acc) begin
        w_out_valid_n = 1'b1;
        w_out_data_n  = w_y;
        w_out_last_n  = s_axis_tlast;
      end else begin
        w_out_valid_n = 1'b0;
      end
    end else if (w_acc) begin
      w_sk_valid_n = 1'b1;
      w_sk_data_n  = w_y;
      w_sk_last_n  = s_axis_tlast;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_ready   <= 1'b1;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_max_val   <= '0;
      r_max_idx   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_sk_valid  <= 1'b0;
      r_sk_data   <= '0;
      r_sk_last   <= 1'b0;
      r_am_valid  <= 1'b0;
      r_am_idx    <= '0;
      r_am_val    <= '0;
      r_err       <= 1'b0;
      r_sat       <= '0;
    end else begin
      r_out_valid <= w_out_valid_n;
      r_out_data  <= w_out_data_n;
      r_out_last  <= w_out_last_n;
      r_sk_valid  <= w_sk_valid_n;
      r_sk_data   <= w_sk_data_n;
      r_sk_last   <= w_sk_last_n;
      r_s_ready   <= ~w_sk_valid_n;
      r_am_valid  <= 1'b0;
      if (w_acc) begin
        if (w_first) r_shift <= cfg_shift;
        if (w_in_range) begin
          r_max_val <= w_best_val;
          r_max_idx <= w_best_idx;
        end
        if (s_axis_tlast) begin
          r_cnt      <= '0;
          r_am_valid <= 1'b1;
          r_am_idx   <= w_best_idx;
          r_am_val   <= w_best_val;
          if (r_cnt != CNT_LAST) r_err <= 1'b1;
        end else if (w_in_range) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (w_sat && (r_sat != 16'hFFFF)) r_sat <= r_sat + 16'd1;
      end
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tlast  = r_out_last;
  assign argmax_valid  = r_am_valid;
  assign argmax_idx    = r_am_idx;
  assign argmax_val    = r_am_val;
  assign err_len       = r_err;
  assign sat_count     = r_sat;

endmodule

// File: tb/tb_nn_requant_argmax.sv
// Randomized bench for nn_requant_argmax: a vector-level reference model predicts every
// output beat, argmax result, length error and saturation count.
module tb_nn_requant_argmax;

  localparam int DATA_W  = 16;
  localparam int N_OUT   = 64;
  localparam int ACC_W   = 39;
  localparam int SHIFT_W = 6;
  localparam int IDX_W   = 6;
  localparam longint YMAX = 32767;
  localparam longint YMIN = -32768;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [ACC_W-1:0]   s_axis_tdata = '0;
  logic               s_axis_tvalid = 1'b0;
  logic               s_axis_tready;
  logic               s_axis_tlast = 1'b0;
  logic [SHIFT_W-1:0] cfg_shift = '0;
  logic [DATA_W-1:0]  m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready = 1'b1;
  logic               m_axis_tlast;
  logic               argmax_valid;
  logic [IDX_W-1:0]   argmax_idx;
  logic [ACC_W-1:0]   argmax_val;
  logic               err_len;
  logic [15:0]        sat_count;

  always #5 clk = ~clk;

  nn_requant_argmax #(.DATA_W(DATA_W), .N_OUT(N_OUT), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) u_dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .cfg_shift(cfg_shift),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .argmax_valid(argmax_valid), .argmax_idx(argmax_idx),
    .argmax_val(argmax_val), .err_len(err_len), .sat_count(sat_count)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  longint q_data[$];
  bit     q_last[$];
  longint q_am_idx[$];
  longint q_am_val[$];
  int     acc_cnt = 0;
  int     drn_cnt = 0;
  int     rdy_mode = 0;
  int     stalls = 0;
  int     pulses = 0;
  bit     exp_err = 0;
  longint exp_sat = 0;
  longint vec[0:127];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint requant(input longint x, input int sh);
    longint r, t;
    r = (sh == 0) ? 64'sd0 : (longint'(1) << (sh - 1));
    t = (x + r) >>> sh;
    if (t > YMAX) t = YMAX;
    else if (t < YMIN) t = YMIN;
    return t;
  endfunction

  function automatic bit clips(input longint x, input int sh);
    longint r, t;
    r = (sh == 0) ? 64'sd0 : (longint'(1) << (sh - 1));
    t = (x + r) >>> sh;
    return (t > YMAX) || (t < YMIN);
  endfunction

  function automatic longint rnd_acc();
    int mb;
    longint v;
    mb = $urandom_range(1, 38);
    v = {$urandom, $urandom};
    v = v & ((longint'(1) << mb) - 1);
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  task automatic expect_beat(input longint x, input int sh, input bit last);
    q_data.push_back(requant(x, sh));
    q_last.push_back(last);
    if (clips(x, sh) && exp_sat < 65535) exp_sat++;
  endtask

  task automatic drive_beat(input longint x, input bit last, input int sh);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 400) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = x[ACC_W-1:0];
      s_axis_tlast  = last;
      cfg_shift     = SHIFT_W'(sh);
      #1;
      acc = s_axis_tready;
      if (!acc) stalls++;
      @(posedge clk);
      n++;
    end
    if (acc) acc_cnt++;
    else check("accept_timeout", acc, 1);
  endtask

  // Whole-vector model: outputs, argmax over the first N_OUT beats (first max wins), length flag.
  task automatic run_vec(input int len, input int sh, input bit chk_timing);
    int lim, bi;
    longint bv;
    lim = (len < N_OUT) ? len : N_OUT;
    bi = 0;
    bv = vec[0];
    for (int i = 1; i < lim; i++) if (vec[i] > bv) begin bv = vec[i]; bi = i; end
    q_am_idx.push_back(bi);
    q_am_val.push_back(bv);
    if (len != N_OUT) exp_err = 1;
    for (int i = 0; i < len; i++) expect_beat(vec[i], sh, i == len - 1);
    for (int i = 0; i < len; i++)
      drive_beat(vec[i], i == len - 1, (i == 0) ? sh : int'($urandom_range(0, ACC_W - 1)));
    if (chk_timing) begin
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      #1;
      check("argmax_timing", argmax_valid, 1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    while (acc_cnt != drn_cnt && n < 2000) begin @(negedge clk); n++; end
    if (acc_cnt != drn_cnt) check("drain_timeout", acc_cnt - drn_cnt, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_s_ready_low", s_axis_tready, 0);
    @(posedge clk);
    q_data.delete(); q_last.delete(); q_am_idx.delete(); q_am_val.delete();
    acc_cnt = 0; drn_cnt = 0; exp_err = 0; exp_sat = 0;
    @(negedge clk);
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    #1;
    check("rst_m_valid", m_axis_tvalid, 0);
    check("rst_argmax_valid", argmax_valid, 0);
    check("rst_err_len", err_len, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_release_s_ready", s_axis_tready, 1);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_err_len"}, err_len, exp_err);
    check({tag, "_sat_count"}, sat_count, exp_sat);
    check({tag, "_am_pending"}, q_am_idx.size(), 0);
  endtask

  // Output/argmax monitor: samples mid-cycle, owns m_axis_tready.
  bit               prev_stall = 0;
  bit               prev_av = 0;
  logic [DATA_W-1:0] prev_d = '0;
  logic             prev_l = 1'b0;
  int               occ;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      occ = acc_cnt - drn_cnt;
      if (!rst) begin
        check("m_valid_vs_occupancy", m_axis_tvalid, occ > 0);
        if (occ >= 2) check("s_ready_while_skid_full", s_axis_tready, 0);
        if (occ > 2) check("occupancy_bound", occ, 2);
        if (prev_stall) begin
          check("stall_hold_valid", m_axis_tvalid, 1);
          check("stall_hold_data", m_axis_tdata, prev_d);
          check("stall_hold_last", m_axis_tlast, prev_l);
        end
      end
      case (rdy_mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = ($urandom_range(0, 1) == 1);
        default: m_axis_tready = 1'b0;
      endcase
      prev_stall = !rst && m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
      if (!rst && m_axis_tvalid && m_axis_tready) begin
        if (q_data.size() == 0) check("out_unexpected", q_data.size(), 1);
        else begin
          check("out_data", $signed(m_axis_tdata), q_data.pop_front());
          check("out_last", m_axis_tlast, q_last.pop_front());
        end
        drn_cnt++;
      end
      if (!rst && argmax_valid) begin
        pulses++;
        check("argmax_pulse_width", prev_av, 0);
        if (q_am_idx.size() == 0) check("argmax_unexpected", q_am_idx.size(), 1);
        else begin
          check("argmax_idx", argmax_idx, q_am_idx.pop_front());
          check("argmax_val", $signed(argmax_val), q_am_val.pop_front());
        end
      end
      prev_av = !rst && argmax_valid;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    do_reset();

    // Ramp with shift 8: full rate, outputs 0..63, argmax at the end.
    for (int i = 0; i < 128; i++) vec[i] = longint'(i) * 256;
    stalls = 0;
    run_vec(64, 8, 1);
    wait_idle();
    check("ramp_no_stall", stalls, 0);
    check_status("ramp");

    // Rounding and saturation corners with shift 4.
    vec[0] = 7; vec[1] = 8; vec[2] = -8; vec[3] = -9;
    vec[4] = longint'(1) << 25; vec[5] = -(longint'(1) << 25);
    for (int i = 6; i < 64; i++) vec[i] = longint'($urandom_range(0, 262143)) - 131072;
    run_vec(64, 4, 0);
    wait_idle();
    check("round_sat_count", sat_count, 2);
    check_status("round");

    // Shift 0 is pure saturation.
    for (int i = 0; i < 64; i++) vec[i] = rnd_acc();
    run_vec(64, 0, 0);
    wait_idle();
    check_status("shift0");

    // Ties keep the lowest index.
    for (int i = 0; i < 64; i++) vec[i] = 5;
    vec[10] = 1000; vec[40] = 1000;
    run_vec(64, $urandom_range(0, 10), 1);
    wait_idle();
    check_status("ties");

    // Random backpressure over three back-to-back vectors.
    rdy_mode = 1;
    p0 = pulses;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 64; i++) vec[i] = rnd_acc();
      run_vec(64, $urandom_range(0, ACC_W - 1), 0);
    end
    wait_idle();
    check("backpressure_pulses", pulses - p0, 3);
    check_status("backpressure");
    rdy_mode = 0;

    // Short vector, a normal one, then an overlong one whose tail holds the largest value.
    for (int i = 0; i < 64; i++) vec[i] = rnd_acc();
    run_vec(32, $urandom_range(0, 20), 0);
    wait_idle();
    check("short_err_len", err_len, 1);
    check_status("short");
    for (int i = 0; i < 64; i++) vec[i] = rnd_acc();
    run_vec(64, $urandom_range(0, 20), 0);
    wait_idle();
    check_status("after_short");
    for (int i = 0; i < 70; i++) vec[i] = rnd_acc();
    vec[66] = longint'(1) << 37;
    run_vec(70, $urandom_range(0, 20), 0);
    wait_idle();
    check_status("long");

    // Reset mid-vector with a stalled output, then a fresh vector at a new shift.
    for (int i = 0; i < 64; i++) vec[i] = rnd_acc();
    for (int i = 0; i < 20; i++) expect_beat(vec[i], 8, 0);
    for (int i = 0; i < 18; i++) drive_beat(vec[i], 0, (i == 0) ? 8 : int'($urandom_range(0, 38)));
    wait_idle();
    rdy_mode = 2;
    drive_beat(vec[18], 0, 1);
    drive_beat(vec[19], 0, 2);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = vec[20][ACC_W-1:0];
    p0 = pulses;
    do_reset();
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    check("reset_no_pulse", pulses - p0, 0);
    for (int i = 0; i < 64; i++) vec[i] = rnd_acc();
    run_vec(64, 3, 1);
    wait_idle();
    check_status("post_reset");
    check("final_out_pending", q_data.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
